// File: rtl/ttt_pkg.sv
// Shared definitions for the N x N, K-in-a-row game engine: game-state codes,
// the FSM state type, scan direction deltas and a constant clog2.
package ttt_pkg;

    localparam logic [2:0] GS_P1    = 3'd0;
    localparam logic [2:0] GS_P2    = 3'd1;
    localparam logic [2:0] GS_DRAW  = 3'd2;
    localparam logic [2:0] GS_P1WIN = 3'd3;
    localparam logic [2:0] GS_P2WIN = 3'd4;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_CHECK,
        ST_OVER
    } state_t;

    // Horizontal, vertical, diagonal, anti-diagonal; the scanner walks each both ways.
    localparam int DIR_DX [4] = '{1, 0, 1,  1};
    localparam int DIR_DY [4] = '{0, 1, 1, -1};

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ttt_win_checker.sv
// Sequential line scanner: one board cell per cycle, 4 directions x 2 halves x
// (WIN_K-1) steps, always running the full schedule.
module ttt_win_checker
    import ttt_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int WIN_K   = 3,
    localparam int CW     = clog2(BOARD_N),
    localparam int CELLS  = BOARD_N * BOARD_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic [CW-1:0]    place_x,
    input  logic [CW-1:0]    place_y,
    input  logic             player,
    input  logic [CELLS-1:0] p1_grid,
    input  logic [CELLS-1:0] p2_grid,
    output logic             done,
    output logic             win
);

    localparam int SW = clog2(WIN_K);
    localparam int RW = clog2(2 * WIN_K);
    localparam int IW = clog2(CELLS);

    logic                 running;
    logic [1:0]           dir;
    logic                 half;
    logic [SW-1:0]        step;
    logic                 alive;
    logic [RW-1:0]        run;
    logic                 win_acc;
    logic                 player_q;
    logic [CW-1:0]        px;
    logic [CW-1:0]        py;
    logic signed [CW:0]   cx;
    logic signed [CW:0]   cy;

    logic                 on_board;
    logic [IW-1:0]        cell_idx;
    logic [CELLS-1:0]     own_grid;
    logic                 hit;
    logic [RW-1:0]        run_next;
    logic                 last_step;
    logic                 dir_win;
    logic [1:0]           dir_nx;
    logic signed [CW:0]   step_dx;
    logic signed [CW:0]   step_dy;

    // The sign bit catches steps below zero, including the overflow past the far edge.
    always_comb begin
        on_board  = !cx[CW] && !cy[CW]
                    && (int'(cx[CW-1:0]) < BOARD_N) && (int'(cy[CW-1:0]) < BOARD_N);
        cell_idx  = IW'(cy[CW-1:0]) * IW'(BOARD_N) + IW'(cx[CW-1:0]);
        own_grid  = player_q ? p2_grid : p1_grid;
        hit       = alive && on_board && own_grid[cell_idx];
        run_next  = run + RW'(hit);
        last_step = (step == SW'(WIN_K - 1));
        dir_win   = ((int'(run_next) + 1) >= WIN_K);
        dir_nx    = dir + 2'd1;
        step_dx   = (CW+1)'(half ? -DIR_DX[dir] : DIR_DX[dir]);
        step_dy   = (CW+1)'(half ? -DIR_DY[dir] : DIR_DY[dir]);
        done      = running && last_step && half && (dir == 2'd3);
        win       = win_acc || (running && last_step && half && dir_win);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running  <= 1'b0;
            dir      <= 2'd0;
            half     <= 1'b0;
            step     <= '0;
            alive    <= 1'b0;
            run      <= '0;
            win_acc  <= 1'b0;
            player_q <= 1'b0;
            px       <= '0;
            py       <= '0;
            cx       <= '0;
            cy       <= '0;
        end else if (clear) begin
            running  <= 1'b0;
        end else if (start) begin
            running  <= 1'b1;
            dir      <= 2'd0;
            half     <= 1'b0;
            step     <= SW'(1);
            alive    <= 1'b1;
            run      <= '0;
            win_acc  <= 1'b0;
            player_q <= player;
            px       <= place_x;
            py       <= place_y;
            cx       <= {1'b0, place_x} + (CW+1)'(DIR_DX[0]);
            cy       <= {1'b0, place_y} + (CW+1)'(DIR_DY[0]);
        end else if (running) begin
            run <= run_next;
            if (!last_step) begin
                step  <= step + SW'(1);
                alive <= hit;
                cx    <= cx + step_dx;
                cy    <= cy + step_dy;
            end else if (!half) begin
                half  <= 1'b1;
                step  <= SW'(1);
                alive <= 1'b1;
                cx    <= {1'b0, px} - (CW+1)'(DIR_DX[dir]);
                cy    <= {1'b0, py} - (CW+1)'(DIR_DY[dir]);
            end else begin
                win_acc <= win_acc || dir_win;
                run     <= '0;
                half    <= 1'b0;
                step    <= SW'(1);
                alive   <= 1'b1;
                dir     <= dir_nx;
                cx      <= {1'b0, px} + (CW+1)'(DIR_DX[dir_nx]);
                cy      <= {1'b0, py} + (CW+1)'(DIR_DY[dir_nx]);
                if (dir == 2'd3) running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ttt_game_engine.sv
// Game core: cursor, both player grids, move count and the PLAY/CHECK/OVER FSM;
// the win scan is delegated to ttt_win_checker.
module ttt_game_engine
    import ttt_pkg::*;
#(
    parameter int BOARD_N     = 3,
    parameter int WIN_K       = 3,
    parameter int CURSOR_WRAP = 1,
    localparam int CW         = clog2(BOARD_N),
    localparam int CELLS      = BOARD_N * BOARD_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btnu,
    input  logic             btnd,
    input  logic             btnl,
    input  logic             btnr,
    input  logic             btns,
    input  logic             new_game,
    output logic [CELLS-1:0] p1_grid,
    output logic [CELLS-1:0] p2_grid,
    output logic [CW-1:0]    cursor_x,
    output logic [CW-1:0]    cursor_y,
    output logic [2:0]       game_state,
    output logic             busy,
    output logic             move_pulse
);

    localparam int MW = clog2(CELLS + 1);
    localparam int IW = clog2(CELLS);
    localparam logic [CW-1:0] CENTER = CW'(BOARD_N / 2);
    localparam logic [CW-1:0] MAXC   = CW'(BOARD_N - 1);

    state_t           state;
    state_t           state_nx;
    logic [MW-1:0]    count;
    logic [MW-1:0]    count_nx;
    logic [CELLS-1:0] p1_nx;
    logic [CELLS-1:0] p2_nx;
    logic [CW-1:0]    cx_nx;
    logic [CW-1:0]    cy_nx;
    logic [2:0]       gs_nx;
    logic             busy_nx;
    logic             pulse_nx;
    logic             check_start;
    logic             chk_done;
    logic             chk_win;
    logic [IW-1:0]    cell_idx;
    logic             occupied;
    logic             player;

    ttt_win_checker #(
        .BOARD_N (BOARD_N),
        .WIN_K   (WIN_K)
    ) u_checker (
        .clk     (clk),
        .rst     (rst),
        .clear   (new_game),
        .start   (check_start),
        .place_x (cursor_x),
        .place_y (cursor_y),
        .player  (player),
        .p1_grid (p1_grid),
        .p2_grid (p2_grid),
        .done    (chk_done),
        .win     (chk_win)
    );

    // new_game dominates; otherwise one button per cycle in PLAY, nothing else in CHECK/OVER.
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        p1_nx       = p1_grid;
        p2_nx       = p2_grid;
        cx_nx       = cursor_x;
        cy_nx       = cursor_y;
        gs_nx       = game_state;
        pulse_nx    = 1'b0;
        check_start = 1'b0;
        cell_idx    = IW'(cursor_y) * IW'(BOARD_N) + IW'(cursor_x);
        occupied    = p1_grid[cell_idx] || p2_grid[cell_idx];
        player      = (game_state == GS_P2);

        if (new_game) begin
            state_nx = ST_PLAY;
            count_nx = '0;
            p1_nx    = '0;
            p2_nx    = '0;
            cx_nx    = CENTER;
            cy_nx    = CENTER;
            gs_nx    = GS_P1;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (btns) begin
                        if (!occupied) begin
                            if (player) p2_nx[cell_idx] = 1'b1;
                            else        p1_nx[cell_idx] = 1'b1;
                            count_nx    = count + MW'(1);
                            pulse_nx    = 1'b1;
                            check_start = 1'b1;
                            state_nx    = ST_CHECK;
                        end
                    end else if (btnu) begin
                        cy_nx = (cursor_y == '0) ? ((CURSOR_WRAP != 0) ? MAXC : cursor_y)
                                                 : cursor_y - 1'b1;
                    end else if (btnd) begin
                        cy_nx = (cursor_y == MAXC) ? ((CURSOR_WRAP != 0) ? '0 : cursor_y)
                                                   : cursor_y + 1'b1;
                    end else if (btnl) begin
                        cx_nx = (cursor_x == '0) ? ((CURSOR_WRAP != 0) ? MAXC : cursor_x)
                                                 : cursor_x - 1'b1;
                    end else if (btnr) begin
                        cx_nx = (cursor_x == MAXC) ? ((CURSOR_WRAP != 0) ? '0 : cursor_x)
                                                   : cursor_x + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (chk_done) begin
                        if (chk_win) begin
                            gs_nx    = player ? GS_P2WIN : GS_P1WIN;
                            state_nx = ST_OVER;
                        end else if (count == MW'(CELLS)) begin
                            gs_nx    = GS_DRAW;
                            state_nx = ST_OVER;
                        end else begin
                            gs_nx    = player ? GS_P1 : GS_P2;
                            state_nx = ST_PLAY;
                        end
                    end
                end
                ST_OVER: begin
                end
                default: state_nx = ST_PLAY;
            endcase
        end

        busy_nx = (state_nx == ST_CHECK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_PLAY;
            count      <= '0;
            p1_grid    <= '0;
            p2_grid    <= '0;
            cursor_x   <= CENTER;
            cursor_y   <= CENTER;
            game_state <= GS_P1;
            busy       <= 1'b0;
            move_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            p1_grid    <= p1_nx;
            p2_grid    <= p2_nx;
            cursor_x   <= cx_nx;
            cursor_y   <= cy_nx;
            game_state <= gs_nx;
            busy       <= busy_nx;
            move_pulse <= pulse_nx;
        end
    end

endmodule

// File: tb/tb_ttt_game_engine.sv
// Directed bench for three engine configurations: 3x3 wrapping, 3x3 saturating
// and 5x5 four-in-a-row, driven from one linear initial block.
module tb_ttt_game_engine;

    localparam logic [5:0] BTN_NEW = 6'b100000;
    localparam logic [5:0] BTN_S   = 6'b010000;
    localparam logic [5:0] BTN_U   = 6'b001000;
    localparam logic [5:0] BTN_D   = 6'b000100;
    localparam logic [5:0] BTN_L   = 6'b000010;
    localparam logic [5:0] BTN_R   = 6'b000001;

    localparam int O_P1 = 0, O_P2 = 1, O_CX = 2, O_CY = 3, O_GS = 4, O_BUSY = 5, O_PULSE = 6;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] in_a, in_b, in_c;

    logic [8:0]  p1_a, p2_a, p1_b, p2_b;
    logic [24:0] p1_c, p2_c;
    logic [1:0]  cx_a, cy_a, cx_b, cy_b;
    logic [2:0]  cx_c, cy_c;
    logic [2:0]  gs_a, gs_b, gs_c;
    logic        busy_a, busy_b, busy_c, pulse_a, pulse_b, pulse_c;

    int tests_run = 0;
    int tests_failed = 0;

    int          cur_x [3];
    int          cur_y [3];
    int          exp_gs [3];
    logic [63:0] exp_p1 [3];
    logic [63:0] exp_p2 [3];
    int          n_of [3]  = '{3, 3, 5};
    int          ck_of [3] = '{16, 16, 24};

    always #5 clk = ~clk;

    ttt_game_engine #(.BOARD_N(3), .WIN_K(3), .CURSOR_WRAP(1)) dut_a (
        .clk(clk), .rst(rst),
        .btnu(in_a[3]), .btnd(in_a[2]), .btnl(in_a[1]), .btnr(in_a[0]),
        .btns(in_a[4]), .new_game(in_a[5]),
        .p1_grid(p1_a), .p2_grid(p2_a), .cursor_x(cx_a), .cursor_y(cy_a),
        .game_state(gs_a), .busy(busy_a), .move_pulse(pulse_a)
    );

    ttt_game_engine #(.BOARD_N(3), .WIN_K(3), .CURSOR_WRAP(0)) dut_b (
        .clk(clk), .rst(rst),
        .btnu(in_b[3]), .btnd(in_b[2]), .btnl(in_b[1]), .btnr(in_b[0]),
        .btns(in_b[4]), .new_game(in_b[5]),
        .p1_grid(p1_b), .p2_grid(p2_b), .cursor_x(cx_b), .cursor_y(cy_b),
        .game_state(gs_b), .busy(busy_b), .move_pulse(pulse_b)
    );

    ttt_game_engine #(.BOARD_N(5), .WIN_K(4), .CURSOR_WRAP(1)) dut_c (
        .clk(clk), .rst(rst),
        .btnu(in_c[3]), .btnd(in_c[2]), .btnl(in_c[1]), .btnr(in_c[0]),
        .btns(in_c[4]), .new_game(in_c[5]),
        .p1_grid(p1_c), .p2_grid(p2_c), .cursor_x(cx_c), .cursor_y(cy_c),
        .game_state(gs_c), .busy(busy_c), .move_pulse(pulse_c)
    );

    function automatic logic [63:0] obs(input int w, input int sel);
        logic [63:0] v [7];
        case (w)
            0: v = '{64'(p1_a), 64'(p2_a), 64'(cx_a), 64'(cy_a), 64'(gs_a), 64'(busy_a), 64'(pulse_a)};
            1: v = '{64'(p1_b), 64'(p2_b), 64'(cx_b), 64'(cy_b), 64'(gs_b), 64'(busy_b), 64'(pulse_b)};
            default: v = '{64'(p1_c), 64'(p2_c), 64'(cx_c), 64'(cy_c), 64'(gs_c), 64'(busy_c), 64'(pulse_c)};
        endcase
        return v[sel];
    endfunction

    task automatic check_output(input string tag, input int w, input int sel, input logic [63:0] expected);
        logic [63:0] got;
        got = obs(w, sel);
        tests_run++;
        assert (got === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s dut%0d: observed %0h expected %0h", tag, w, got, expected);
        end
    endtask

    task automatic check_model(input string tag, input int w);
        check_output({tag, "_p1"}, w, O_P1, exp_p1[w]);
        check_output({tag, "_p2"}, w, O_P2, exp_p2[w]);
        check_output({tag, "_cx"}, w, O_CX, 64'(cur_x[w]));
        check_output({tag, "_cy"}, w, O_CY, 64'(cur_y[w]));
        check_output({tag, "_gs"}, w, O_GS, 64'(exp_gs[w]));
    endtask

    task automatic reset_model(input int w);
        cur_x[w]  = n_of[w] / 2;
        cur_y[w]  = n_of[w] / 2;
        exp_gs[w] = 0;
        exp_p1[w] = '0;
        exp_p2[w] = '0;
    endtask

    task automatic drive(input int w, input logic [5:0] v);
        case (w)
            0:       in_a = v;
            1:       in_b = v;
            default: in_c = v;
        endcase
    endtask

    // Inputs change on falling edges, so the next rising edge samples them once.
    task automatic apply_stimulus(input int w, input logic [5:0] v);
        @(negedge clk);
        drive(w, v);
        @(negedge clk);
        drive(w, 6'b0);
    endtask

    task automatic move_to(input int w, input int x, input int y);
        while (cur_x[w] < x) begin apply_stimulus(w, BTN_R); cur_x[w]++; end
        while (cur_x[w] > x) begin apply_stimulus(w, BTN_L); cur_x[w]--; end
        while (cur_y[w] < y) begin apply_stimulus(w, BTN_D); cur_y[w]++; end
        while (cur_y[w] > y) begin apply_stimulus(w, BTN_U); cur_y[w]--; end
        check_output("move_cx", w, O_CX, 64'(x));
        check_output("move_cy", w, O_CY, 64'(y));
    endtask

    task automatic new_game_clear(input int w);
        apply_stimulus(w, BTN_NEW);
        reset_model(w);
        check_model("clear", w);
        check_output("clear_busy", w, O_BUSY, 64'd0);
        check_output("clear_pulse", w, O_PULSE, 64'd0);
    endtask

    task automatic play(input int w, input int x, input int y, input int new_gs);
        int idx;
        int old_gs;
        move_to(w, x, y);
        old_gs = exp_gs[w];
        idx    = y * n_of[w] + x;
        if (old_gs == 0) exp_p1[w][idx] = 1'b1;
        else             exp_p2[w][idx] = 1'b1;
        apply_stimulus(w, BTN_S);
        check_output("place_pulse", w, O_PULSE, 64'd1);
        check_model("place", w);
        for (int i = 0; i < ck_of[w]; i++) begin
            check_output("busy_hold", w, O_BUSY, 64'd1);
            if (i == 1) check_output("pulse_fall", w, O_PULSE, 64'd0);
            if (i == ck_of[w] - 1) check_output("gs_hold", w, O_GS, 64'(old_gs));
            @(negedge clk);
        end
        exp_gs[w] = new_gs;
        check_output("busy_fall", w, O_BUSY, 64'd0);
        check_output("gs_result", w, O_GS, 64'(exp_gs[w]));
    endtask

    initial begin
        in_a = '0;
        in_b = '0;
        in_c = '0;
        rst  = 1'b0;
        for (int w = 0; w < 3; w++) reset_model(w);

        repeat (2) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            check_model("reset", w);
            check_output("reset_busy", w, O_BUSY, 64'd0);
            check_output("reset_pulse", w, O_PULSE, 64'd0);
        end
        rst = 1'b1;

        // Left at the edge: wrap versus saturate.
        apply_stimulus(0, BTN_L);
        check_output("wrap_l1", 0, O_CX, 64'd0);
        apply_stimulus(0, BTN_L);
        check_output("wrap_l2", 0, O_CX, 64'd2);
        check_output("wrap_y", 0, O_CY, 64'd1);
        cur_x[0] = 2;
        apply_stimulus(1, BTN_L);
        check_output("sat_l1", 1, O_CX, 64'd0);
        apply_stimulus(1, BTN_L);
        check_output("sat_l2", 1, O_CX, 64'd0);
        cur_x[1] = 0;

        // p1 completes the top row on move 5.
        play(0, 0, 0, 1);
        play(0, 0, 1, 0);
        play(0, 1, 0, 1);
        play(0, 1, 1, 0);
        play(0, 2, 0, 3);
        apply_stimulus(0, BTN_D);
        check_model("over_btnd", 0);
        apply_stimulus(0, BTN_S);
        check_output("over_pulse", 0, O_PULSE, 64'd0);
        check_output("over_busy", 0, O_BUSY, 64'd0);
        check_model("over_btns", 0);

        // Full board without a line, with an occupied-cell select after move 1.
        new_game_clear(0);
        play(0, 0, 0, 1);
        apply_stimulus(0, BTN_S);
        check_output("occ_pulse", 0, O_PULSE, 64'd0);
        check_output("occ_busy", 0, O_BUSY, 64'd0);
        check_model("occ", 0);
        play(0, 1, 0, 0);
        play(0, 2, 0, 1);
        play(0, 1, 1, 0);
        play(0, 0, 1, 1);
        play(0, 2, 1, 0);
        play(0, 1, 2, 1);
        play(0, 0, 2, 0);
        play(0, 2, 2, 2);

        // Ninth move completes column 2: win beats draw.
        new_game_clear(0);
        play(0, 0, 0, 1);
        play(0, 1, 0, 0);
        play(0, 2, 0, 1);
        play(0, 1, 1, 0);
        play(0, 2, 1, 1);
        play(0, 0, 1, 0);
        play(0, 1, 2, 1);
        play(0, 0, 2, 0);
        play(0, 2, 2, 3);

        // Select plus up together places only; new_game mid-scan leaves no result behind.
        apply_stimulus(1, BTN_S | BTN_U);
        exp_p1[1][3] = 1'b1;
        check_output("simul_pulse", 1, O_PULSE, 64'd1);
        check_output("simul_busy", 1, O_BUSY, 64'd1);
        check_model("simul", 1);
        repeat (4) @(negedge clk);
        new_game_clear(1);
        for (int i = 0; i < 20; i++) begin
            check_output("stale_busy", 1, O_BUSY, 64'd0);
            check_output("stale_gs", 1, O_GS, 64'd0);
            @(negedge clk);
        end
        play(1, 1, 1, 1);

        // 5x5, K=4: a row split across a wrap must not win; the anti-diagonal does.
        play(2, 0, 0, 1);
        play(2, 3, 0, 0);
        play(2, 3, 3, 1);
        play(2, 1, 2, 0);
        play(2, 4, 3, 1);
        play(2, 0, 3, 0);
        play(2, 0, 4, 1);
        play(2, 4, 0, 0);
        play(2, 1, 4, 1);
        play(2, 2, 1, 4);

        // Asynchronous reset in the middle of a scan.
        new_game_clear(0);
        apply_stimulus(0, BTN_S);
        check_output("prerst_busy", 0, O_BUSY, 64'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        reset_model(0);
        reset_model(2);
        check_model("midrst", 0);
        check_output("midrst_busy", 0, O_BUSY, 64'd0);
        check_output("midrst_pulse", 0, O_PULSE, 64'd0);
        check_model("midrst", 2);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ttt_game_engine.md
# ttt_game_engine

Parametrised game core for the N×N, K-in-a-row family of board games; generalises the fixed 3×3 tic-tac-toe core. Takes debounced single-cycle button pulses, moves a cursor, places pieces for alternating players, detects win/draw with a sequential line scanner, and exposes both player grids plus game state to the VGA and seven-segment display logic.

## Interface
- `BOARD_N`, 3: board side, legal range 3..8.
- `WIN_K`, 3: run length needed to win, 3..`BOARD_N`.
- `CURSOR_WRAP`, 1: 1 = cursor wraps at edges, 0 = cursor saturates.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `btnu`, `btnd`, `btnl`, `btnr`, `btns`  in  1 each  debounced one-cycle pulses: up, down, left, right, select.
- `new_game`  in  1  synchronous one-cycle clear request.
- `p1_grid`, `p2_grid`  out  `BOARD_N*BOARD_N`  occupancy; bit `y*BOARD_N+x`, bit 0 = top-left.
- `cursor_x`, `cursor_y`  out  `CW = clog2(BOARD_N)`  column and row of the cursor.
- `game_state`  out  3  0 p1 turn, 1 p2 turn, 2 draw, 3 p1 wins, 4 p2 wins.
- `busy`  out  1  high while the win check runs.
- `move_pulse`  out  1  one-cycle strobe when a placement is accepted.

## Operation
- FSM states: PLAY, CHECK, OVER.
- Reset (`rst`=0) or `new_game` gives: grids 0, cursor (`BOARD_N/2`, `BOARD_N/2`), `game_state`=0, `busy`=0, `move_pulse`=0, move count 0, FSM PLAY. `new_game` overrides every other input in any state, including mid-CHECK.
- PLAY: at most one button acts per cycle. Priority: `btns` > `btnu` > `btnd` > `btnl` > `btnr`.
- Up/down change `cursor_y` by -1/+1 and left/right change `cursor_x` by -1/+1. At an edge the cursor wraps to the opposite edge if `CURSOR_WRAP`=1, else it holds.
- `btns` on an empty cell: set the current player's grid bit, increment the move count, pulse `move_pulse`, go to CHECK.
- `btns` on an occupied cell is ignored: no pulse, no turn change.
- CHECK: `busy`=1 and all buttons are ignored. For each of the 4 directions (horizontal, vertical, diagonal, anti-diagonal), walk forward then backward from the placed cell, up to `WIN_K-1` steps each. Each half counts own-player cells until the first off-board or non-own cell; later steps of that half do not count.
  - Win in a direction if 1 + forward count + backward count ≥ `WIN_K`.
- CHECK exit:
  - Any direction wins: `game_state` = 3 or 4, FSM goes to OVER.
  - No win and move count = `BOARD_N²`: `game_state`=2, FSM goes to OVER.
  - Otherwise `game_state` toggles 0↔1 and FSM returns to PLAY.
  - A win on the final move reports win, not draw.
- OVER: grids, cursor and state are frozen. Only `new_game` or reset leaves OVER.
- Move count width is `clog2(BOARD_N²+1)`. The scanner's signed coordinate math is `CW+1` bits wide, and its off-board test is coordinate < 0 or ≥ `BOARD_N`.

## Timing
- Cursor, grid bit, and `move_pulse` update at the clock edge that samples the button (edge E0). `move_pulse` is high for the one cycle after E0.
- `busy` rises at E0. CHECK lasts exactly `8*(WIN_K-1)` cycles for every placement, with one step per cycle. Off-board or broken steps still take their cycle; there is no early exit.
- `game_state` updates and `busy` falls at edge E0 + `8*(WIN_K-1)`: 16 cycles for K=3, 32 for K=5. A button sampled at that same edge is ignored. Buttons are accepted from the next edge.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `ttt_pkg`:
  - game-state constants `GS_P1`, `GS_P2`, `GS_DRAW`, `GS_P1WIN`, `GS_P2WIN`;
  - FSM state enum;
  - direction delta constants (dx, dy) for the four directions;
  - a `clog2` function.
- Sub-module `ttt_win_checker`: inputs are start, placed (x, y), player, and both grids. Outputs are done and win. It holds the direction/half/step counters. The top level keeps the FSM, the cursor, the grids and the move count.

## Test plan
- N=3, K=3: reset, then press `btnl` twice. Expect cursor (1,1) → (0,1) → (2,1) with wrap. With `CURSOR_WRAP`=0, expect (0,1) → (0,1).
- N=3: p1 plays (0,0),(1,0),(2,0); p2 plays (0,1),(1,1). Expect `game_state`=3 exactly 16 cycles after the p1 (2,0) select; `busy` is high for those 16 cycles. Further `btns` presses change nothing.
- N=3: `btns` on an occupied cell → no `move_pulse`, grids unchanged, `game_state` unchanged.
- N=3: full-board no-win sequence → `game_state`=2 after the 9th move. Also a win on the 9th move → `game_state`=3.
- N=5, K=4: anti-diagonal p2 run (3,0),(2,1),(1,2),(0,3), with the last piece placed in the middle of the run → `game_state`=4 after 24 cycles. A wrapped-around line does not count.
- Simultaneous `btns`+`btnu` → only a placement occurs. `new_game` at CHECK cycle 5 → full clear, no stale result. `rst` low mid-CHECK → reset values immediately.
